bus_arbiter4: RTL and testbench
===============================

# bus_arbiter4

Round-robin arbiter and sequencer for the shared 32-bit 4:1 operand/bus multiplexer in the RISC-V datapath. Four requesters compete for the one shared path. The block grants exactly one requester at a time and drives the multiplexer's 2-bit select to that requester's index. It holds the grant until the owner signals completion or a hold-timeout expires, then re-arbitrates fairly.

## Interface
Parameters:
- MAX_HOLD, 16: maximum consecutive grant cycles per ownership. Legal range 1..255.

Ports:
- clk  input  1  system clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector. Bit i = requester i wants the shared path.
- done  input  4  completion strobe. Bit i = requester i finishes its transfer this cycle.
- gnt  output  4  registered one-hot grant. All-zero when idle.
- sel  output  2  registered mux select. Index of the current or most recent owner.
- busy  output  1  registered. 1 while any grant is active (equals |gnt).
- timeout  output  1  registered one-cycle pulse when a grant is force-released by the hold limit.

## Operation
- State machine with two states, IDLE and GRANT.
- Round-robin pointer `last` is a 2-bit register holding the index of the last granted requester.
- IDLE:
  - If req is nonzero, pick the first set bit scanning last+1, last+2, last+3, last (mod 4).
  - Load gnt to one-hot(winner), sel to winner, last to winner, and clear the hold counter. Go to GRANT.
  - If req is zero, stay in IDLE with gnt = 0.
- GRANT (owner o = last):
  - Release condition: done[o]=1, OR req[o]=0, OR hold counter = MAX_HOLD-1.
  - On release: gnt goes to 0 and state goes to IDLE next cycle.
  - timeout pulses 1 next cycle only when the release is caused solely by the hold limit, i.e. done[o]=0 and req[o]=1.
  - Otherwise increment the hold counter. Hold counter is 8 bits and saturates only via the release rule; it never wraps.
- done[j] and req[j] for j≠o are ignored while in GRANT. Pending requests wait.
- sel is not cleared on release; it keeps the last owner's index so the mux output is stable while idle.
- A winner is re-eligible only after every other pending requester has been served, because priority rotates.
- Reset (rst=1 at any edge, including mid-grant) sets:
  - state=IDLE, gnt=0, sel=0, busy=0, timeout=0, hold counter=0.
  - last=3, so requester 0 has first priority after reset.
  - Any in-flight grant is dropped without a timeout pulse.

## Timing
- Reset values: gnt=4'b0000, sel=2'b00, busy=0, timeout=0.
- Grant latency: req sampled in IDLE at edge N, so gnt/sel/busy are valid after edge N. That is 1 cycle from request to grant.
- Release latency: release condition sampled at edge M, so gnt=0 and busy=0 after edge M.
- Every ownership is followed by at least one idle cycle. Back-to-back owners are separated by exactly 1 cycle with gnt=0.
- Maximum grant length is MAX_HOLD cycles. With MAX_HOLD=1, every grant lasts exactly 1 cycle, and timeout pulses unless done[o] is high in that cycle.
- done[o] asserted in the first grant cycle gives a 1-cycle grant.
- gnt is always one-hot or zero. sel equals the index of the set gnt bit whenever gnt≠0.
- timeout is high for exactly 1 cycle, coincident with the first idle cycle after a forced release.

## Test plan
- Reset: assert rst with req=4'b1111 for 2 cycles, then release. Expect gnt=0, sel=0, busy=0, timeout=0 while in reset. Expect gnt=4'b0001, sel=0 one cycle after rst deasserts.
- Single requester: req=4'b0100, done[2] pulsed in the 3rd grant cycle. Expect gnt=4'b0100 and sel=2 for exactly 3 cycles, then gnt=0 with sel still 2, and timeout never set.
- Fairness: req=4'b1111 held, each owner pulses done in its first grant cycle. Expect grant order 0,1,2,3,0, each 1 cycle long, with gnt=0 cycles between grants.
- Timeout: MAX_HOLD=16, req=4'b0010 held, done=0. Expect gnt=4'b0010 for exactly 16 cycles, then gnt=0 with timeout=1 for 1 cycle. The next grant is requester 1 again, since it is the only requester.
- Foreign done and drop: owner 0 is granted and done=4'b1110 is applied, so the grant is held. Then req[0] drops to 0. Expect release next cycle with timeout=0, and requester 1 (pending) granted one idle cycle later.
- Reset mid-grant: requester 3 is owner at hold count 5 when rst is pulsed for 1 cycle with req=4'b1001. Expect gnt=0 and no timeout pulse, then requester 0 is granted first.

Source files
------------

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter for the shared 4:1 operand/bus mux: grants one requester at
// a time and holds the grant until completion, request drop, or the hold limit.
module bus_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic [7:0] hold_q, hold_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] sel_q, sel_d;
  logic       busy_q, busy_d;
  logic       timeout_q, timeout_d;

  logic [1:0] winner;
  logic [1:0] owner;
  logic       release_c;

  // First set request bit scanning last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    hold_d    = hold_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    winner    = rr_pick(req, last_q);
    owner     = last_q;
    release_c = done[owner] | ~req[owner] | (hold_q == HOLD_LAST);

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          gnt_d   = 4'b0001 << winner;
          sel_d   = winner;
          last_d  = winner;
          hold_d  = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (release_c) begin
          gnt_d     = 4'b0000;
          state_d   = IDLE;
          // Only a pure hold-limit release is reported as a timeout.
          timeout_d = ~done[owner] & req[owner];
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        state_d = IDLE;
      end
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= 2'd3;
      hold_q    <= 8'd0;
      gnt_q     <= 4'b0000;
      sel_q     <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign sel     = sel_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Scoreboard bench for bus_arbiter4: expected outputs are queued as each cycle's
// stimulus is driven, then compared against the captured outputs per scenario.
module tb_bus_arbiter4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       timeout;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       to;
  } obs_t;

  obs_t  exp_q[$];
  obs_t  obs_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  bus_arbiter4 #(.MAX_HOLD(16)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .sel(sel), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue the outputs expected after the next edge,
  // and capture what the DUT shows 1 time unit after that edge.
  task automatic cyc(input string nm, input logic [3:0] r, input logic [3:0] d,
                     input logic rs, input logic [3:0] eg, input logic [1:0] es,
                     input logic et);
    obs_t e;
    obs_t o;
    req  = r;
    done = d;
    rst  = rs;
    e.gnt = eg; e.sel = es; e.busy = |eg; e.to = et;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    o.gnt = gnt; o.sel = sel; o.busy = busy; o.to = timeout;
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    obs_t e, o; string n;
    cyc("reset_c0", 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc("reset_c1", 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc("reset_first_gnt", 4'b1111, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("reset_drop", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc("reset_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                 n, o.gnt, o.sel, o.busy, o.to, e.gnt, e.sel, e.busy, e.to);
      end
    end
  endtask

  task automatic test_single();
    obs_t e, o; string n;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("single_gnt%0d", i), 4'b0100, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b0);
    cyc("single_done", 4'b0100, 4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0);
    cyc("single_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                 n, o.gnt, o.sel, o.busy, o.to, e.gnt, e.sel, e.busy, e.to);
      end
    end
  endtask

  task automatic test_fairness();
    obs_t e, o; string n;
    logic [3:0] oh;
    logic [1:0] ix;
    cyc("fair_rst", 4'b1111, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      ix = 2'(k % 4);
      oh = 4'b0001 << ix;
      cyc($sformatf("fair_gnt%0d", k), 4'b1111, 4'b0000, 1'b0, oh, ix, 1'b0);
      cyc($sformatf("fair_gap%0d", k), 4'b1111, oh, 1'b0, 4'b0000, ix, 1'b0);
    end
    cyc("fair_idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                 n, o.gnt, o.sel, o.busy, o.to, e.gnt, e.sel, e.busy, e.to);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t e, o; string n;
    for (int i = 0; i < 16; i++)
      cyc($sformatf("to_hold%0d", i), 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc("to_pulse", 4'b0010, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b1);
    cyc("to_regrant", 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc("to_drop", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                 n, o.gnt, o.sel, o.busy, o.to, e.gnt, e.sel, e.busy, e.to);
      end
    end
  endtask

  task automatic test_foreign_done();
    obs_t e, o; string n;
    cyc("fd_gnt0", 4'b0011, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("fd_hold1", 4'b0011, 4'b1110, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("fd_hold2", 4'b0011, 4'b1110, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("fd_drop", 4'b0010, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    cyc("fd_gnt1", 4'b0010, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b0);
    cyc("fd_end", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                 n, o.gnt, o.sel, o.busy, o.to, e.gnt, e.sel, e.busy, e.to);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    obs_t e, o; string n;
    for (int i = 0; i < 6; i++)
      cyc($sformatf("rm_own3_%0d", i), 4'b1000, 4'b0000, 1'b0, 4'b1000, 2'd3, 1'b0);
    cyc("rm_rst", 4'b1001, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0);
    cyc("rm_first0", 4'b1001, 4'b0000, 1'b0, 4'b0001, 2'd0, 1'b0);
    cyc("rm_end", 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n = name_q.pop_front();
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL %s: got gnt=%b sel=%0d busy=%b timeout=%b, want gnt=%b sel=%0d busy=%b timeout=%b",
                 n, o.gnt, o.sel, o.busy, o.to, e.gnt, e.sel, e.busy, e.to);
      end
    end
  endtask

  initial begin
    rst  = 1'b1;
    req  = 4'b0000;
    done = 4'b0000;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_foreign_done();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
